// File: rtl/note_sequencer_pkg.sv
// note_sequencer_pkg: states, note codes, tone half-periods and song ROM (GAP state exists only with NOTE_SEQUENCER_GAP_EN)
package note_pkg;
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
`ifdef NOTE_SEQUENCER_GAP_EN
    GAP,
`endif
    DONE
  } state_t;
  localparam logic [2:0] REST = 3'd0;
  localparam logic [2:0] DO = 3'd1;
  localparam logic [2:0] RE = 3'd2;
  localparam logic [2:0] MI = 3'd3;
  localparam logic [2:0] FA = 3'd4;
  localparam logic [2:0] SO = 3'd5;
  localparam logic [2:0] LA = 3'd6;
  localparam logic [2:0] SI = 3'd7;
  function automatic logic [16:0] half_per(input logic [2:0] n);
    case (n)
      DO: return 17'd95420;
      RE: return 17'd85034;
      MI: return 17'd75758;
      FA: return 17'd71633;
      SO: return 17'd63776;
      LA: return 17'd56818;
      SI: return 17'd50607;
      default: return 17'd0;
    endcase
  endfunction
  function automatic logic [6:0] song_rom(input logic [4:0] i);
    case (i)
      5'd0, 5'd1: return {DO, 4'd1};
      5'd2, 5'd3: return {SO, 4'd1};
      5'd4, 5'd5: return {LA, 4'd1};
      5'd6: return {SO, 4'd2};
      5'd7, 5'd8: return {FA, 4'd1};
      5'd9, 5'd10: return {MI, 4'd1};
      5'd11, 5'd12: return {RE, 4'd1};
      5'd13: return {DO, 4'd2};
      default: return 7'd0;
    endcase
  endfunction
endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: control and display/buzzer signals of the note sequencer
interface note_sequencer_if;
  logic start;
  logic stop;
  logic loop_en;
  logic [2:0] spec_flag;
  logic beep;
  logic playing;
  logic done;
  logic [4:0] note_idx;
  modport master (output start, stop, loop_en, input spec_flag, beep, playing, done, note_idx);
  modport slave (input start, stop, loop_en, output spec_flag, beep, playing, done, note_idx);
endinterface

// File: rtl/note_sequencer_tone_gen.sv
// tone_gen: square wave toggling every half cycles while enabled, phase reset on restart
module tone_gen (
  input logic clk,
  input logic rst_n,
  input logic [16:0] half,
  input logic en,
  input logic restart,
  output logic beep
);
  logic [16:0] cnt;
  // half-period counter; silent and zeroed whenever disabled or restarting
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= 17'd0;
      beep <= 1'b0;
    end else if (!en || restart) begin
      cnt <= 17'd0;
      beep <= 1'b0;
    end else if (cnt + 17'd1 >= half) begin
      cnt <= 17'd0;
      beep <= ~beep;
    end else
      cnt <= cnt + 17'd1;
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: ROM-driven note player with beat timer; NOTE_SEQUENCER_GAP_EN inserts a silent gap after each note
module note_sequencer
  import note_pkg::*;
#(
  parameter int BEAT_CYC = 12_500_000,
  parameter int SONG_LEN = 32,
  parameter int TONE_SHIFT = 0
) (
  input logic clk,
  input logic rst_n,
  note_sequencer_if.slave bus
);
  state_t state, nxt, adv;
  logic [4:0] idx, nxt_idx, adv_idx;
  logic [31:0] tmr;
  logic [3:0] beat_cnt;
  logic [6:0] entry, nxt_entry;
  logic [2:0] spec_flag;
  logic playing, done, tick, last;
`ifdef NOTE_SEQUENCER_GAP_EN
  localparam int GAP_CYC = BEAT_CYC / 4 > 0 ? BEAT_CYC / 4 : 1;
`endif
  assign entry = song_rom(idx);
  assign nxt_entry = song_rom(idx + 5'd1);
  assign tick = state == PLAY && tmr == 32'(BEAT_CYC - 1);
  assign last = idx == 5'(SONG_LEN - 1) || nxt_entry[3:0] == 4'd0;
  assign adv = last && !bus.loop_en ? DONE : LOAD;
  assign adv_idx = !last ? idx + 5'd1 : bus.loop_en ? 5'd0 : idx;
  assign bus.spec_flag = spec_flag;
  assign bus.playing = playing;
  assign bus.done = done;
  assign bus.note_idx = idx;
  // next state and entry index; stop overrides everything, including start
  always_comb begin
    nxt = state;
    nxt_idx = idx;
    case (state)
      IDLE: begin
        nxt = bus.start ? LOAD : IDLE;
        nxt_idx = bus.start ? 5'd0 : idx;
      end
      LOAD: begin
        nxt = entry[3:0] != 4'd0 ? PLAY : bus.loop_en ? LOAD : DONE;
        nxt_idx = entry[3:0] == 4'd0 && bus.loop_en ? 5'd0 : idx;
      end
      PLAY:
        if (tick && beat_cnt == 4'd1) begin
`ifdef NOTE_SEQUENCER_GAP_EN
          nxt = GAP;
`else
          nxt = adv;
          nxt_idx = adv_idx;
`endif
        end
`ifdef NOTE_SEQUENCER_GAP_EN
      GAP:
        if (tmr == 32'(GAP_CYC - 1)) begin
          nxt = adv;
          nxt_idx = adv_idx;
        end
`endif
      default: nxt = IDLE;
    endcase
    if (bus.stop) nxt = IDLE;
  end
  // state, timers and registered outputs derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= 5'd0;
      tmr <= 32'd0;
      beat_cnt <= 4'd0;
      spec_flag <= 3'd0;
      playing <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      idx <= nxt_idx;
      tmr <= nxt == state && nxt != IDLE && !tick ? tmr + 32'd1 : 32'd0;
      beat_cnt <= state == LOAD ? entry[3:0] : beat_cnt - {3'd0, tick};
      spec_flag <= nxt == PLAY ? entry[6:4] : REST;
      playing <= nxt != IDLE && nxt != DONE;
      done <= nxt == DONE;
    end
  tone_gen u_tone (
    .clk(clk),
    .rst_n(rst_n),
    .half(half_per(entry[6:4]) >> TONE_SHIFT),
    .en(nxt == PLAY && entry[6:4] != REST),
    .restart(state != PLAY),
    .beep(bus.beep)
  );
endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter BEAT_CYC, default 12_500_000, giving clk cycles per beat (250 ms at 50 MHz).
REQ-002 SHALL have parameter SONG_LEN, default 32, giving the number of song ROM entries (max 32).
REQ-003 SHALL have parameter TONE_SHIFT, default 0, giving the right-shift applied to tone half-periods (simulation speed-up).
REQ-004 SHALL have clk, input, 1: clock.
REQ-005 SHALL have rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have start, input, 1: one-cycle pulse that begins playback.
REQ-007 SHALL have stop, input, 1: level or pulse that aborts playback.
REQ-008 SHALL have loop_en, input, 1: restart at entry 0 after the last note.
REQ-009 SHALL have spec_flag, output, 3: current note code, 0 = rest, 1..7 = do..si; this is the lantern display input.
REQ-010 SHALL have beep, output, 1: square-wave tone for the buzzer.
REQ-011 SHALL have playing, output, 1: high in LOAD, PLAY and GAP.
REQ-012 SHALL have done, output, 1: one-cycle pulse at natural song end.
REQ-013 SHALL have note_idx, output, 5: index of the current ROM entry.

Function
REQ-014 SHALL read ROM entries of 7 bits: note[6:4], dur[3:0] in beats; dur=0 is the end-of-song marker.
REQ-015 SHALL implement states IDLE, LOAD, PLAY, GAP and DONE.
REQ-016 IDLE SHALL go to LOAD on start, with note_idx=0.
REQ-017 LOAD SHALL take 1 cycle to register the entry: dur≠0 goes to PLAY with beat_cnt=dur and the beat timer cleared; dur=0 is treated as the end of the song.
REQ-018 PLAY SHALL drive spec_flag=note and generate a beat tick every BEAT_CYC cycles, decrementing beat_cnt on each tick.
REQ-019 PLAY SHALL leave when beat_cnt reaches 0 on a tick.
REQ-020 A note SHALL therefore last exactly dur*BEAT_CYC cycles in PLAY.
REQ-021 At the end of a note, SHALL advance: note_idx==SONG_LEN-1 or the next entry is the marker counts as the song end; otherwise note_idx+1 and go to LOAD.
REQ-022 At song end with loop_en=1, SHALL wrap note_idx to 0 and go to LOAD; with loop_en=0, SHALL go to DONE.
REQ-023 DONE SHALL assert done for exactly 1 cycle, then go to IDLE.
REQ-024 stop=1 in any non-IDLE state SHALL force IDLE on the next edge; spec_flag, beep and playing go 0; done is not asserted.
REQ-025 If start and stop are both 1 in the same cycle, stop SHALL win.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 beep SHALL toggle every (HALF_PER[note] >> TONE_SHIFT) cycles while in PLAY with note≠0; otherwise beep=0.
REQ-028 The tone counter SHALL restart on every entry into PLAY.
REQ-029 spec_flag SHALL be 0 in IDLE, LOAD, GAP and DONE.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 Assertion of rst_n=0 SHALL asynchronously force: state IDLE, spec_flag=0, beep=0, playing=0, done=0, note_idx=0, all counters 0.
REQ-032 Reset mid-song SHALL discard position; the next start plays from entry 0.

Configuration
REQ-033 SHALL honour macro NOTE_SEQUENCER_GAP_EN.
REQ-034 With NOTE_SEQUENCER_GAP_EN defined, PLAY SHALL go to GAP for BEAT_CYC/4 cycles (spec_flag=0, beep=0) before advancing, separating repeated notes.
REQ-035 Without NOTE_SEQUENCER_GAP_EN, the GAP state SHALL be absent and PLAY SHALL advance directly.

Structure
REQ-036 Package note_pkg SHALL hold the state enum, the note code constants (REST=0, DO=1 .. SI=7), the HALF_PER table at 50 MHz (95420, 85034, 75758, 71633, 63776, 56818, 50607) and the default song ROM.
REQ-037 The default song ROM SHALL hold 1,1,5,5,6,6,5(dur2),4,4,3,3,2,2,1(dur2), then the marker.
REQ-038 Sub-module tone_gen (half-period in, enable, restart, beep out) SHALL generate the tone; the FSM and the beat timer SHALL stay in note_sequencer.

Verification
REQ-039 Bench SHALL use BEAT_CYC=4, TONE_SHIFT=14, and NOTE_SEQUENCER_GAP_EN undefined unless stated.
REQ-040 Reset scenario: rst_n low mid-PLAY -> all outputs 0 immediately; start -> note_idx=0, spec_flag=1 after 2 cycles.
REQ-041 Timing scenario: start -> spec_flag sequence 1,1,5,5,6,6,5,... each held 4 cycles; the 7th note held 8 cycles.
REQ-042 End/loop scenario: loop_en=0 -> done pulses once 1 cycle after the last note, then playing=0; loop_en=1 -> note_idx wraps 13->0, done never pulses.
REQ-043 Abort scenario: stop and start in the same cycle during PLAY -> IDLE next edge, spec_flag=0; later start restarts at entry 0.
REQ-044 Tone scenario: note 6 -> beep toggles every 3 cycles (56818>>14); with NOTE_SEQUENCER_GAP_EN defined, 1-cycle gaps with spec_flag=0 between notes.
